// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Shares one UART byte transmitter between NREQ byte producers. A round-robin
// arbiter grants one byte at a time. tx_start is held high for the whole frame.
// Frame completion is taken from tx_done. After each frame, an idle gap is
// enforced before the next grant.
//
// Sequence: IDLE -> SEND -> DRAIN -> GAP -> IDLE.
// A SEND that times out goes straight to GAP.
// When GAP_CYCLES is 0, the GAP state is skipped.
//
// Parameters
//   NREQ            number of requesters (2, 4 or 8)
//   GIDW            width of gnt_id, log2(NREQ)
//   GAP_CYCLES      idle cycles between frames, 0 = back-to-back
//   TIMEOUT_CYCLES  cycles allowed in SEND before the frame is aborted
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active high
//   req_valid    per-requester "has a byte" flags
//   req_data     requester i's byte at req_data[8*i +: 8]
//   req_ready    one-hot, single-cycle accept pulse
//   tx_start     level request to the transmitter, held for the whole frame
//   tx_data      byte presented to the transmitter, stable while tx_start=1
//   tx_done      transmitter stop-bit indication (level)
//   busy         high whenever the scheduler is not idle
//   gnt_id       index of the requester owning the current/last frame
//   frame_done   single-cycle pulse on successful frame completion
//   err_timeout  single-cycle pulse when a frame is aborted by timeout
// -----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int NREQ           = 4,
    parameter int GIDW           = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic [GIDW-1:0]   gnt_id,
    output logic              frame_done,
    output logic              err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DRAIN,
        GAP
    } state_t;

    // Terminal counts of the 16-bit timeout and gap counters.
    // GAP_LAST is never used when GAP_CYCLES is 0, because GAP is skipped then.
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
    localparam state_t      AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t          state;
    logic [GIDW-1:0] last_grant;
    logic [15:0]     tmo_cnt;
    logic [15:0]     gap_cnt;

    logic            pick_valid;
    logic [GIDW-1:0] pick_idx;

    // Round-robin pick: the first valid index after last_grant, wrapping.
    // The loop runs from the lowest priority down to the highest, so the
    // highest-priority hit is assigned last and wins. NREQ is a power of two,
    // so GIDW-bit addition wraps exactly at NREQ.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; otherwise a path that skips the assignment infers a latch.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[last_grant + GIDW'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = last_grant + GIDW'(k);
            end
        end
    end

    // NOTE: all state and outputs use non-blocking assignments in a single
    // clocked block. The reset branch is sampled on the clock edge
    // (synchronous), so reset timing stays inside the normal timing paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= GIDW'(NREQ - 1);
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            gnt_id      <= '0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // Pulse outputs default low; a transition below may raise them for one cycle.
            req_ready   <= '0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        tx_data             <= req_data[{pick_idx, 3'b000} +: 8];
                        gnt_id              <= pick_idx;
                        last_grant          <= pick_idx;
                        req_ready[pick_idx] <= 1'b1;
                        tx_start            <= 1'b1;
                        busy                <= 1'b1;
                        tmo_cnt             <= '0;
                        state               <= SEND;
                    end
                end

                SEND: begin
                    // Success is checked first, so a tx_done that arrives on
                    // the final allowed cycle still completes the frame.
                    if (tx_done) begin
                        tx_start   <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DRAIN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tx_start    <= 1'b0;
                        err_timeout <= 1'b1;
                        gap_cnt     <= '0;
                        busy        <= (AFTER_FRAME != IDLE);
                        state       <= AFTER_FRAME;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                DRAIN: begin
                    // Wait out the rest of the stop bit so the transmitter
                    // cannot see a new tx_start while still finishing.
                    if (!tx_done) begin
                        gap_cnt <= '0;
                        busy    <= (AFTER_FRAME != IDLE);
                        state   <= AFTER_FRAME;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
